ysyx_23060025_axi_arbiter: RTL and testbench
============================================

// Module: ysyx_23060025_axi_arbiter
// PURPOSE
//  Two-master / one-slave AXI-lite arbiter sitting directly downstream of the IFU fetch port and the LSU memory port.
//  Selects one master per transaction, forwards its channels to the single slave bus, and routes responses back.
//  Master 0 = IFU (read only). Master 1 = LSU (read + write).
//  A grant is locked from address phase until response handshake: at most one outstanding transaction.
// PARAMETERS
//  DATA_LEN        32   data width of r/w data channels
//  ADDR_LEN        32   address width
//  TIMEOUT_CYCLES  255  cycles from grant to forced error response (used only with ARB_TIMEOUT_EN)
// PORTS  (name  dir  width  meaning; "{a,b}" lists a channel bundle)
//  clock                            in   1         single clock, rising edge
//  rstn                             in   1         asynchronous, active-low reset
//  ifu_addr_r_{addr,valid}_i        in   32/1      IFU read-address request
//  ifu_addr_r_ready_o               out  1         IFU read address accepted
//  ifu_r_{data,resp,valid}_o        out  32/2/1    IFU read-data response
//  ifu_r_ready_i                    in   1         IFU accepts read data
//  lsu_addr_r_{addr,valid,size}_i   in   32/1/3    LSU read-address request
//  lsu_addr_r_ready_o               out  1         LSU read address accepted
//  lsu_r_{data,resp,valid}_o        out  32/2/1    LSU read-data response
//  lsu_r_ready_i                    in   1         LSU accepts read data
//  lsu_addr_w_{addr,valid,size}_i   in   32/1/3    LSU write-address request
//  lsu_addr_w_ready_o / lsu_w_ready_o  out  1/1    LSU write address / write data accepted
//  lsu_w_{data,strb,valid}_i        in   32/4/1    LSU write data, byte strobe
//  lsu_bkwd_{resp,valid}_o          out  2/1       LSU write response
//  lsu_bkwd_ready_i                 in   1         LSU accepts write response
//  addr_r_{addr,valid,size}_o, addr_r_ready_i          slave read-address channel
//  r_{data,resp,valid}_i, r_ready_o                    slave read-data channel
//  addr_w_{addr,valid,size}_o, addr_w_ready_i          slave write-address channel
//  w_{data,strb,valid}_o, w_ready_i                    slave write-data channel
//  bkwd_{resp,valid}_i, bkwd_ready_o                   slave write-response channel
// BEHAVIOUR
//  - FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. Registered state; all channel muxing is combinational from state.
//  - Reset: asserting rstn low forces IDLE immediately, including mid-transaction.
//    All valid/ready outputs are 0 during and after reset. Address/data/strb/size/resp outputs are 0 when not granted.
//  - IDLE arbitration, fixed priority (evaluated every IDLE cycle):
//    1. lsu_addr_r_valid_i -> LSU_RD
//    2. else lsu_addr_w_valid_i -> LSU_WR
//    3. else ifu_addr_r_valid_i -> IFU_RD
//    Simultaneous LSU read and write valids: the read wins; the write stays pending.
//  - Grant latency: one cycle. Nothing is forwarded in IDLE; all slave-side valid/ready outputs are 0.
//  - IFU_RD / LSU_RD:
//    - Granted master's addr_r bundle and r_ready are forwarded; slave r_* and addr_r_ready are routed back to it.
//    - IFU-forwarded addr_r_size_o = 3'b010.
//    - Exit to IDLE on the cycle after the r_valid_i & r_ready handshake.
//  - LSU_WR:
//    - LSU addr_w, w and bkwd_ready are forwarded; slave ready and bkwd are routed back.
//    - Exit to IDLE on the cycle after the bkwd_valid_i & lsu_bkwd_ready_i handshake.
//  - Non-granted master: ready/valid outputs held 0. Its requests stay pending and are not dropped.
//  - Slave r_valid_i/bkwd_valid_i while not in the matching state: ignored. r_ready_o/bkwd_ready_o stay 0.
//  - Master holding ready low: grant and response data stay stable until the handshake; no data loss.
//  - Back-to-back requests: the earliest new grant is the cycle after return to IDLE, i.e. 1 idle cycle per transaction.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - An 8-bit-min counter (width = $clog2(TIMEOUT_CYCLES+1)) clears on grant and increments each non-IDLE cycle.
//  - When it reaches TIMEOUT_CYCLES, the slave-side valids drop. The arbiter drives to the granted master
//    r_valid/bkwd_valid=1, resp=2'b11, data=0, holds it until the master's ready, then returns to IDLE.
//  - The late slave response is ignored.
//  ARB_TIMEOUT_EN undefined: no counter logic; the arbiter waits indefinitely for the slave.
// TESTING
//  1. IFU read only: ifu addr 0x3000_0000 valid.
//     -> Next cycle addr_r_addr_o=0x3000_0000, size 3'b010.
//     -> Slave returns 0xDEADBEEF, resp 0: IFU sees it; IDLE one cycle later.
//  2. IFU and LSU read valid in the same IDLE cycle.
//     -> LSU granted first; ifu_addr_r_ready_o=0 until the LSU r handshake.
//     -> IFU then granted, forwarded 2 cycles after the LSU handshake.
//  3. LSU sb: addr 0x0F00_0001, strb 4'b0010, data 0x0000_AB00; IFU request raised mid-write.
//     -> Slave sees identical aw/w values; bkwd resp 2'b00 reaches the LSU.
//     -> IFU is served only afterwards.
//  4. Slave r_valid delayed 5 cycles, lsu_r_ready_i low 2 extra cycles.
//     -> Grant held; lsu_r_data_o stable 0x1234_5678 throughout; single handshake.
//  5. rstn pulled low during LSU_RD.
//     -> All slave valids 0 in the same cycle.
//     -> After release, an IFU read to 0x2000_0004 completes normally.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave silent on an LSU read.
//     -> At grant+16: lsu_r_valid_o=1, resp 2'b11, data 0.
//     -> A late slave r_valid is ignored.

Source files
------------

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter with one outstanding transaction.
// Optional ARB_TIMEOUT_EN: after TIMEOUT_CYCLES granted cycles the arbiter answers the master itself with resp 2'b11.
module ysyx_23060025_axi_arbiter #(
    parameter int DATA_LEN       = 32,
    parameter int ADDR_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    rstn,
    // IFU (master 0)
    input  logic [ADDR_LEN-1:0]     ifu_addr_r_addr_i,
    input  logic                    ifu_addr_r_valid_i,
    output logic                    ifu_addr_r_ready_o,
    output logic [DATA_LEN-1:0]     ifu_r_data_o,
    output logic [1:0]              ifu_r_resp_o,
    output logic                    ifu_r_valid_o,
    input  logic                    ifu_r_ready_i,
    // LSU (master 1)
    input  logic [ADDR_LEN-1:0]     lsu_addr_r_addr_i,
    input  logic                    lsu_addr_r_valid_i,
    input  logic [2:0]              lsu_addr_r_size_i,
    output logic                    lsu_addr_r_ready_o,
    output logic [DATA_LEN-1:0]     lsu_r_data_o,
    output logic [1:0]              lsu_r_resp_o,
    output logic                    lsu_r_valid_o,
    input  logic                    lsu_r_ready_i,
    input  logic [ADDR_LEN-1:0]     lsu_addr_w_addr_i,
    input  logic                    lsu_addr_w_valid_i,
    input  logic [2:0]              lsu_addr_w_size_i,
    output logic                    lsu_addr_w_ready_o,
    input  logic [DATA_LEN-1:0]     lsu_w_data_i,
    input  logic [DATA_LEN/8-1:0]   lsu_w_strb_i,
    input  logic                    lsu_w_valid_i,
    output logic                    lsu_w_ready_o,
    output logic [1:0]              lsu_bkwd_resp_o,
    output logic                    lsu_bkwd_valid_o,
    input  logic                    lsu_bkwd_ready_i,
    // Slave
    output logic [ADDR_LEN-1:0]     addr_r_addr_o,
    output logic                    addr_r_valid_o,
    output logic [2:0]              addr_r_size_o,
    input  logic                    addr_r_ready_i,
    input  logic [DATA_LEN-1:0]     r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    output logic [ADDR_LEN-1:0]     addr_w_addr_o,
    output logic                    addr_w_valid_o,
    output logic [2:0]              addr_w_size_o,
    input  logic                    addr_w_ready_i,
    output logic [DATA_LEN-1:0]     w_data_o,
    output logic [DATA_LEN/8-1:0]   w_strb_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    input  logic [1:0]              bkwd_resp_i,
    input  logic                    bkwd_valid_i,
    output logic                    bkwd_ready_o,
    // Debug view of the arbiter state
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   timed_out;

`ifdef ARB_TIMEOUT_EN
    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

    logic [CW-1:0] cnt_q, cnt_d;

    assign timed_out = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES));

    // Held at zero while idle so the first granted cycle counts as 0; saturates at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!timed_out) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the timeout feature the arbiter waits on the slave forever.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    // Handshakes: a beat transfers on a rising edge where both valid and ready are high; a granted
    // master's valid/ready pass straight through, so the slave and master see one shared handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_addr_r_valid_i) begin
                    state_d = LSU_RD;
                end else if (lsu_addr_w_valid_i) begin
                    state_d = LSU_WR;
                end else if (ifu_addr_r_valid_i) begin
                    state_d = IFU_RD;
                end
            end
            IFU_RD: if (ifu_r_ready_i && (r_valid_i || timed_out)) state_d = IDLE;
            LSU_RD: if (lsu_r_ready_i && (r_valid_i || timed_out)) state_d = IDLE;
            LSU_WR: if (lsu_bkwd_ready_i && (bkwd_valid_i || timed_out)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state_o = state_q;

    always_comb begin
        ifu_addr_r_ready_o = 1'b0;
        ifu_r_data_o       = '0;
        ifu_r_resp_o       = 2'b00;
        ifu_r_valid_o      = 1'b0;
        lsu_addr_r_ready_o = 1'b0;
        lsu_r_data_o       = '0;
        lsu_r_resp_o       = 2'b00;
        lsu_r_valid_o      = 1'b0;
        lsu_addr_w_ready_o = 1'b0;
        lsu_w_ready_o      = 1'b0;
        lsu_bkwd_resp_o    = 2'b00;
        lsu_bkwd_valid_o   = 1'b0;
        addr_r_addr_o      = '0;
        addr_r_valid_o     = 1'b0;
        addr_r_size_o      = 3'b000;
        r_ready_o          = 1'b0;
        addr_w_addr_o      = '0;
        addr_w_valid_o     = 1'b0;
        addr_w_size_o      = 3'b000;
        w_data_o           = '0;
        w_strb_o           = '0;
        w_valid_o          = 1'b0;
        bkwd_ready_o       = 1'b0;
        unique case (state_q)
            IDLE: ;
            IFU_RD: begin
                addr_r_addr_o = ifu_addr_r_addr_i;
                addr_r_size_o = 3'b010;
                if (timed_out) begin
                    ifu_r_resp_o  = 2'b11;
                    ifu_r_valid_o = 1'b1;
                end else begin
                    addr_r_valid_o     = ifu_addr_r_valid_i;
                    ifu_addr_r_ready_o = addr_r_ready_i;
                    ifu_r_data_o       = r_data_i;
                    ifu_r_resp_o       = r_resp_i;
                    ifu_r_valid_o      = r_valid_i;
                    r_ready_o          = ifu_r_ready_i;
                end
            end
            LSU_RD: begin
                addr_r_addr_o = lsu_addr_r_addr_i;
                addr_r_size_o = lsu_addr_r_size_i;
                if (timed_out) begin
                    lsu_r_resp_o  = 2'b11;
                    lsu_r_valid_o = 1'b1;
                end else begin
                    addr_r_valid_o     = lsu_addr_r_valid_i;
                    lsu_addr_r_ready_o = addr_r_ready_i;
                    lsu_r_data_o       = r_data_i;
                    lsu_r_resp_o       = r_resp_i;
                    lsu_r_valid_o      = r_valid_i;
                    r_ready_o          = lsu_r_ready_i;
                end
            end
            LSU_WR: begin
                addr_w_addr_o = lsu_addr_w_addr_i;
                addr_w_size_o = lsu_addr_w_size_i;
                w_data_o      = lsu_w_data_i;
                w_strb_o      = lsu_w_strb_i;
                if (timed_out) begin
                    lsu_bkwd_resp_o  = 2'b11;
                    lsu_bkwd_valid_o = 1'b1;
                end else begin
                    addr_w_valid_o     = lsu_addr_w_valid_i;
                    lsu_addr_w_ready_o = addr_w_ready_i;
                    w_valid_o          = lsu_w_valid_i;
                    lsu_w_ready_o      = w_ready_i;
                    lsu_bkwd_resp_o    = bkwd_resp_i;
                    lsu_bkwd_valid_o   = bkwd_valid_i;
                    bkwd_ready_o       = lsu_bkwd_ready_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_arbiter.sv
// Directed bench for the AXI-lite arbiter: an ownership model predicts every output each cycle,
// and literal checks pin the key values of each scenario.
module tb_ysyx_23060025_axi_arbiter;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] ifu_addr_r_addr_i = '0;
    logic        ifu_addr_r_valid_i = 1'b0, ifu_r_ready_i = 1'b0;
    logic [31:0] lsu_addr_r_addr_i = '0, lsu_addr_w_addr_i = '0, lsu_w_data_i = '0;
    logic        lsu_addr_r_valid_i = 1'b0, lsu_r_ready_i = 1'b0, lsu_addr_w_valid_i = 1'b0;
    logic [2:0]  lsu_addr_r_size_i = '0, lsu_addr_w_size_i = '0;
    logic [3:0]  lsu_w_strb_i = '0;
    logic        lsu_w_valid_i = 1'b0, lsu_bkwd_ready_i = 1'b0;
    logic        addr_r_ready_i = 1'b0, r_valid_i = 1'b0, addr_w_ready_i = 1'b0;
    logic        w_ready_i = 1'b0, bkwd_valid_i = 1'b0;
    logic [31:0] r_data_i = '0;
    logic [1:0]  r_resp_i = '0, bkwd_resp_i = '0;

    logic        ifu_addr_r_ready_o, ifu_r_valid_o, lsu_addr_r_ready_o, lsu_r_valid_o;
    logic [31:0] ifu_r_data_o, lsu_r_data_o, addr_r_addr_o, addr_w_addr_o, w_data_o;
    logic [1:0]  ifu_r_resp_o, lsu_r_resp_o, lsu_bkwd_resp_o, dbg_state_o;
    logic        lsu_addr_w_ready_o, lsu_w_ready_o, lsu_bkwd_valid_o;
    logic        addr_r_valid_o, r_ready_o, addr_w_valid_o, w_valid_o, bkwd_ready_o;
    logic [2:0]  addr_r_size_o, addr_w_size_o;
    logic [3:0]  w_strb_o;

    always #5 clock = ~clock;

    ysyx_23060025_axi_arbiter #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .rstn(rstn),
        .ifu_addr_r_addr_i(ifu_addr_r_addr_i), .ifu_addr_r_valid_i(ifu_addr_r_valid_i),
        .ifu_addr_r_ready_o(ifu_addr_r_ready_o), .ifu_r_data_o(ifu_r_data_o),
        .ifu_r_resp_o(ifu_r_resp_o), .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_ready_i(ifu_r_ready_i),
        .lsu_addr_r_addr_i(lsu_addr_r_addr_i), .lsu_addr_r_valid_i(lsu_addr_r_valid_i),
        .lsu_addr_r_size_i(lsu_addr_r_size_i), .lsu_addr_r_ready_o(lsu_addr_r_ready_o),
        .lsu_r_data_o(lsu_r_data_o), .lsu_r_resp_o(lsu_r_resp_o), .lsu_r_valid_o(lsu_r_valid_o),
        .lsu_r_ready_i(lsu_r_ready_i),
        .lsu_addr_w_addr_i(lsu_addr_w_addr_i), .lsu_addr_w_valid_i(lsu_addr_w_valid_i),
        .lsu_addr_w_size_i(lsu_addr_w_size_i), .lsu_addr_w_ready_o(lsu_addr_w_ready_o),
        .lsu_w_data_i(lsu_w_data_i), .lsu_w_strb_i(lsu_w_strb_i), .lsu_w_valid_i(lsu_w_valid_i),
        .lsu_w_ready_o(lsu_w_ready_o), .lsu_bkwd_resp_o(lsu_bkwd_resp_o),
        .lsu_bkwd_valid_o(lsu_bkwd_valid_o), .lsu_bkwd_ready_i(lsu_bkwd_ready_i),
        .addr_r_addr_o(addr_r_addr_o), .addr_r_valid_o(addr_r_valid_o), .addr_r_size_o(addr_r_size_o),
        .addr_r_ready_i(addr_r_ready_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .addr_w_addr_o(addr_w_addr_o), .addr_w_valid_o(addr_w_valid_o), .addr_w_size_o(addr_w_size_o),
        .addr_w_ready_i(addr_w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .bkwd_resp_i(bkwd_resp_i), .bkwd_valid_i(bkwd_valid_i), .bkwd_ready_o(bkwd_ready_o),
        .dbg_state_o(dbg_state_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model: who owns the slave (0 none, 1 IFU read, 2 LSU read, 3 LSU write) and cycles since grant.
    int   own = 0;
    int   cnt = 0;
    logic to;
    logic done;
`ifdef ARB_TIMEOUT_EN
    assign to = (own != 0) && (cnt >= TO);
`else
    assign to = 1'b0;
`endif

    always @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            own = 0;
            cnt = 0;
        end else if (own == 0) begin
            cnt = 0;
            if (lsu_addr_r_valid_i)      own = 2;
            else if (lsu_addr_w_valid_i) own = 3;
            else if (ifu_addr_r_valid_i) own = 1;
        end else begin
            case (own)
                1:       done = ifu_r_ready_i && (to || r_valid_i);
                2:       done = lsu_r_ready_i && (to || r_valid_i);
                default: done = lsu_bkwd_ready_i && (to || bkwd_valid_i);
            endcase
            if (done) begin
                own = 0;
                cnt = 0;
            end else if (cnt < TO) begin
                cnt++;
            end
        end
    end

    logic [35:0] e_ifu, e_lsu_r, a_ifu, a_lsu_r;
    logic [4:0]  e_lsu_w, a_lsu_w;
    logic [36:0] e_slv_r, a_slv_r;
    logic [73:0] e_slv_w, a_slv_w;

    assign a_ifu   = {ifu_addr_r_ready_o, ifu_r_data_o, ifu_r_resp_o, ifu_r_valid_o};
    assign a_lsu_r = {lsu_addr_r_ready_o, lsu_r_data_o, lsu_r_resp_o, lsu_r_valid_o};
    assign a_lsu_w = {lsu_addr_w_ready_o, lsu_w_ready_o, lsu_bkwd_resp_o, lsu_bkwd_valid_o};
    assign a_slv_r = {addr_r_addr_o, addr_r_valid_o, addr_r_size_o, r_ready_o};
    assign a_slv_w = {addr_w_addr_o, addr_w_valid_o, addr_w_size_o, w_data_o, w_strb_o, w_valid_o, bkwd_ready_o};

    always_comb begin
        e_ifu = '0; e_lsu_r = '0; e_lsu_w = '0; e_slv_r = '0; e_slv_w = '0;
        if (own == 1) begin
            e_ifu   = to ? {1'b0, 32'h0, 2'b11, 1'b1} : {addr_r_ready_i, r_data_i, r_resp_i, r_valid_i};
            e_slv_r = {ifu_addr_r_addr_i, ifu_addr_r_valid_i && !to, 3'b010, ifu_r_ready_i && !to};
        end else if (own == 2) begin
            e_lsu_r = to ? {1'b0, 32'h0, 2'b11, 1'b1} : {addr_r_ready_i, r_data_i, r_resp_i, r_valid_i};
            e_slv_r = {lsu_addr_r_addr_i, lsu_addr_r_valid_i && !to, lsu_addr_r_size_i, lsu_r_ready_i && !to};
        end else if (own == 3) begin
            e_lsu_w = to ? {1'b0, 1'b0, 2'b11, 1'b1} : {addr_w_ready_i, w_ready_i, bkwd_resp_i, bkwd_valid_i};
            e_slv_w = {lsu_addr_w_addr_i, lsu_addr_w_valid_i && !to, lsu_addr_w_size_i,
                       lsu_w_data_i, lsu_w_strb_i, lsu_w_valid_i && !to, lsu_bkwd_ready_i && !to};
        end
    end

    always @(negedge clock) begin
        chk("model_ifu", a_ifu, e_ifu);
        chk("model_lsu_r", a_lsu_r, e_lsu_r);
        chk("model_lsu_w", a_lsu_w, e_lsu_w);
        chk("model_slv_r", a_slv_r, e_slv_r);
        chk("model_slv_w", a_slv_w, e_slv_w);
    end

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_valids", {addr_r_valid_o, addr_w_valid_o, w_valid_o, r_ready_o, bkwd_ready_o,
                             ifu_r_valid_o, lsu_r_valid_o, lsu_bkwd_valid_o}, 0);
        tick();
        rstn = 1'b1;

        // 1: lone IFU read
        ifu_addr_r_addr_i = 32'h3000_0000; ifu_addr_r_valid_i = 1'b1; addr_r_ready_i = 1'b1;
        @(negedge clock);
        chk("t1_idle_no_fwd", addr_r_valid_o, 0);
        tick();
        @(negedge clock);
        chk("t1_addr", addr_r_addr_o, 32'h3000_0000);
        chk("t1_size", addr_r_size_o, 3'b010);
        chk("t1_valid_ready", {addr_r_valid_o, ifu_addr_r_ready_o}, 2'b11);
        tick();
        ifu_addr_r_valid_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = 32'hDEAD_BEEF; r_resp_i = 2'b00; ifu_r_ready_i = 1'b1;
        @(negedge clock);
        chk("t1_rdata", ifu_r_data_o, 32'hDEAD_BEEF);
        chk("t1_rvalid", ifu_r_valid_o, 1);
        tick();
        r_valid_i = 1'b0; ifu_r_ready_i = 1'b0;
        @(negedge clock);
        chk("t1_back_idle", {ifu_r_valid_o, r_ready_o}, 0);

        // 2: IFU and LSU read together, LSU first
        lsu_addr_r_addr_i = 32'h8000_0010; lsu_addr_r_size_i = 3'b010; lsu_addr_r_valid_i = 1'b1;
        ifu_addr_r_addr_i = 32'h3000_0004; ifu_addr_r_valid_i = 1'b1;
        tick();
        @(negedge clock);
        chk("t2_lsu_addr", addr_r_addr_o, 32'h8000_0010);
        chk("t2_ifu_blocked", {ifu_addr_r_ready_o, lsu_addr_r_ready_o}, 2'b01);
        tick();
        lsu_addr_r_valid_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = 32'hCAFE_0001; lsu_r_ready_i = 1'b1;
        @(negedge clock);
        chk("t2_lsu_rdata", lsu_r_data_o, 32'hCAFE_0001);
        chk("t2_ifu_still_blocked", ifu_addr_r_ready_o, 0);
        tick();
        r_valid_i = 1'b0; lsu_r_ready_i = 1'b0;
        @(negedge clock);
        chk("t2_idle_gap", {addr_r_valid_o, ifu_addr_r_ready_o}, 0);
        tick();
        @(negedge clock);
        chk("t2_ifu_addr", addr_r_addr_o, 32'h3000_0004);
        chk("t2_ifu_granted", {addr_r_valid_o, ifu_addr_r_ready_o}, 2'b11);
        tick();
        ifu_addr_r_valid_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = 32'h0000_0013; ifu_r_ready_i = 1'b1;
        tick();
        r_valid_i = 1'b0; ifu_r_ready_i = 1'b0;

        // 3: LSU byte store, IFU raised mid-write
        lsu_addr_w_addr_i = 32'h0F00_0001; lsu_addr_w_size_i = 3'b000; lsu_addr_w_valid_i = 1'b1;
        lsu_w_data_i = 32'h0000_AB00; lsu_w_strb_i = 4'b0010; lsu_w_valid_i = 1'b1;
        addr_w_ready_i = 1'b1; w_ready_i = 1'b1;
        tick();
        ifu_addr_r_addr_i = 32'h3000_0008; ifu_addr_r_valid_i = 1'b1;
        @(negedge clock);
        chk("t3_aw", {addr_w_addr_o, addr_w_size_o, addr_w_valid_o}, {32'h0F00_0001, 3'b000, 1'b1});
        chk("t3_w", {w_data_o, w_strb_o, w_valid_o, lsu_w_ready_o}, {32'h0000_AB00, 4'b0010, 1'b1, 1'b1});
        chk("t3_ifu_held", addr_r_valid_o, 0);
        tick();
        lsu_addr_w_valid_i = 1'b0; lsu_w_valid_i = 1'b0;
        bkwd_valid_i = 1'b1; bkwd_resp_i = 2'b00; lsu_bkwd_ready_i = 1'b1;
        @(negedge clock);
        chk("t3_bresp", {lsu_bkwd_valid_o, lsu_bkwd_resp_o, bkwd_ready_o}, 4'b1001);
        chk("t3_ifu_blocked", ifu_addr_r_ready_o, 0);
        tick();
        bkwd_valid_i = 1'b0; lsu_bkwd_ready_i = 1'b0;
        @(negedge clock);
        chk("t3_idle_gap", addr_r_valid_o, 0);
        tick();
        @(negedge clock);
        chk("t3_ifu_after", {addr_r_addr_o, addr_r_valid_o}, {32'h3000_0008, 1'b1});
        tick();
        ifu_addr_r_valid_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = 32'h0000_0011; ifu_r_ready_i = 1'b1;
        tick();
        r_valid_i = 1'b0; ifu_r_ready_i = 1'b0;

        // 4: slow slave, LSU back-pressures the read data
        lsu_addr_r_addr_i = 32'h8000_0100; lsu_addr_r_valid_i = 1'b1;
        tick();
        tick();
        lsu_addr_r_valid_i = 1'b0;
        repeat (5) tick();
        @(negedge clock);
        chk("t4_no_data_yet", {lsu_r_valid_o, addr_r_addr_o}, {1'b0, 32'h8000_0100});
        r_valid_i = 1'b1; r_data_i = 32'h1234_5678; lsu_r_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clock);
            chk("t4_stall_data", {lsu_r_valid_o, lsu_r_data_o, r_ready_o}, {1'b1, 32'h1234_5678, 1'b0});
        end
        lsu_r_ready_i = 1'b1;
        tick();
        @(negedge clock);
        chk("t4_single_hs", {lsu_r_valid_o, r_ready_o}, 0);
        tick();
        r_valid_i = 1'b0; lsu_r_ready_i = 1'b0;

        // 5: reset during an LSU read
        lsu_addr_r_addr_i = 32'h8000_0200; lsu_addr_r_valid_i = 1'b1;
        tick();
        @(negedge clock);
        chk("t5_granted", addr_r_valid_o, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_async_drop", {addr_r_valid_o, lsu_addr_r_ready_o, r_ready_o}, 0);
        lsu_addr_r_valid_i = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        ifu_addr_r_addr_i = 32'h2000_0004; ifu_addr_r_valid_i = 1'b1;
        tick();
        @(negedge clock);
        chk("t5_ifu_addr", {addr_r_addr_o, addr_r_valid_o}, {32'h2000_0004, 1'b1});
        tick();
        ifu_addr_r_valid_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = 32'hA5A5_0004; ifu_r_ready_i = 1'b1;
        @(negedge clock);
        chk("t5_ifu_rdata", {ifu_r_valid_o, ifu_r_data_o}, {1'b1, 32'hA5A5_0004});
        tick();
        r_valid_i = 1'b0; ifu_r_ready_i = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // 6: silent slave on an LSU read
        lsu_addr_r_addr_i = 32'h8000_0300; lsu_addr_r_valid_i = 1'b1;
        tick();
        lsu_addr_r_valid_i = 1'b0;
        repeat (TO - 1) tick();
        @(negedge clock);
        chk("t6_before_to", lsu_r_valid_o, 0);
        tick();
        @(negedge clock);
        chk("t6_to_resp", {lsu_r_valid_o, lsu_r_resp_o, lsu_r_data_o, r_ready_o}, {1'b1, 2'b11, 32'h0, 1'b0});
        r_valid_i = 1'b1; r_data_i = 32'hBAD0_BAD0;
        #1;
        chk("t6_late_ignored", {lsu_r_data_o, r_ready_o}, 0);
        lsu_r_ready_i = 1'b1;
        tick();
        r_valid_i = 1'b0; lsu_r_ready_i = 1'b0;
        @(negedge clock);
        chk("t6_back_idle", lsu_r_valid_o, 0);
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
